irq_controller: RTL and testbench

//  8-line programmable interrupt controller feeding the core's irq/intr/intl toggle handshake.

---
 rtl/irq_controller_pkg.sv | 29 ++
 rtl/irq_prio_enc.sv | 27 ++
 rtl/irq_controller.sv | 172 +++++++++++++++++
 tb/tb_irq_controller.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
// -----------------------------------------------------------------------------
// irq_controller_pkg
//   Shared definitions for the 8-line programmable interrupt controller:
//   register offsets on the core port bus, command-bit positions, FSM state
//   encoding and a small helper for non-specific end-of-interrupt.
// -----------------------------------------------------------------------------
package irq_controller_pkg;

    // Register offsets relative to PORT_BASE
    localparam logic [15:0] PIC_OFS_CMD = 16'd0;   // write: command, read: IRR
    localparam logic [15:0] PIC_OFS_IMR = 16'd1;   // read/write: interrupt mask

    // Command word bit positions
    localparam int OCW_EOI_BIT = 5;                // non-specific EOI
    localparam int OCW_VEC_BIT = 4;                // load vector base from [7:3]

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_WAIT = 2'd2
    } irq_state_e;

    // Clear the lowest set bit; zero stays zero, so EOI with nothing in
    // service is naturally a no-op.
    function automatic logic [7:0] clear_lowest(input logic [7:0] v);
        return v & (v - 8'd1);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
//   8-bit fixed-priority encoder: bit 0 is the highest priority.
//   Ports:
//     req_i  in  8  request vector
//     vld_o  out 1  at least one request bit set
//     idx_o  out 3  index of the lowest set bit (0 when vld_o = 0)
// -----------------------------------------------------------------------------
module irq_prio_enc (
    input  logic [7:0] req_i,
    output logic       vld_o,
    output logic [2:0] idx_o
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        vld_o = 1'b0;
        idx_o = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_i[i]) begin
                vld_o = 1'b1;
                idx_o = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//   8-line programmable interrupt controller for the core's irq/intr/intl
//   toggle handshake. Rising edges on irq_line are latched into IRR, masked
//   by IMR, prioritised (bit 0 highest) and nested against ISR. One vector
//   at a time is presented on irq; intr toggles to request, the core
//   acknowledges by copying intr onto intl.
//   Ports:
//     clock     in   1   system clock (posedge)
//     reset_n   in   1   synchronous, active-low reset
//     irq_line  in   8   external request levels
//     port      in   16  core port address
//     port_clk  in   1   core port strobe (rising edge = one access)
//     port_w    in   1   1 = write, 0 = read
//     port_o    in   8   write data from core
//     port_rd   out  8   read data (IRR at BASE+0, IMR at BASE+1, else 0)
//     port_sel  out  1   address hits BASE+0 or BASE+1
//     irq       out  8   vector {vec_base, level}
//     intr      out  1   request toggle
//     intl      in   1   core's acknowledge copy of intr
// -----------------------------------------------------------------------------
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter logic [15:0] PORT_BASE = 16'h0020,
    parameter logic [4:0]  VEC_RESET = 5'h01
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  irq_line,
    input  logic [15:0] port,
    input  logic        port_clk,
    input  logic        port_w,
    input  logic [7:0]  port_o,
    output logic [7:0]  port_rd,
    output logic        port_sel,
    output logic [7:0]  irq,
    output logic        intr,
    input  logic        intl
);

    irq_state_e  state_q, state_d;
    logic [7:0]  line_q;
    logic        pclk_q;
    logic [7:0]  irr_q, irr_d;
    logic [7:0]  isr_q, isr_d;
    logic [7:0]  imr_q, imr_d;
    logic [4:0]  vbase_q, vbase_d;
    logic [7:0]  irq_q, irq_d;
    logic        intr_q, intr_d;
    logic [2:0]  lvl_q, lvl_d;

    logic [7:0]  rise;
    logic        strobe;
    logic        sel_cmd, sel_imr;
    logic        wr_cmd, wr_imr;
    logic [7:0]  pend;
    logic        cand_vld, isr_vld;
    logic [2:0]  cand, isr_top;
    logic        eligible;
    logic        deliver;

    assign rise    = irq_line & ~line_q;
    assign strobe  = port_clk & ~pclk_q;
    assign sel_cmd = (port == PORT_BASE + PIC_OFS_CMD);
    assign sel_imr = (port == PORT_BASE + PIC_OFS_IMR);
    assign wr_cmd  = strobe & port_w & sel_cmd;
    assign wr_imr  = strobe & port_w & sel_imr;
    assign pend    = irr_q & ~imr_q;

    irq_prio_enc u_pend_enc (
        .req_i (pend),
        .vld_o (cand_vld),
        .idx_o (cand)
    );

    irq_prio_enc u_isr_enc (
        .req_i (isr_q),
        .vld_o (isr_vld),
        .idx_o (isr_top)
    );

    // Fully nested: any in-service level at or above the candidate's
    // priority (index <= cand) blocks it, including the same level.
    assign eligible = cand_vld & (~isr_vld | (isr_top > cand));

    // FSM next state and delivery outputs
    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        irq_d   = irq_q;
        intr_d  = intr_q;
        deliver = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (eligible && (intr_q == intl)) begin
                    state_d = ST_SEL;
                    lvl_d   = cand;
                end
            end
            ST_SEL: begin
                // The request may have been masked or cleared since IDLE.
                if (pend[lvl_q]) begin
                    deliver = 1'b1;
                    irq_d   = {vbase_q, lvl_q};
                    intr_d  = ~intr_q;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (intl == intr_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register file next state
    always_comb begin
        irr_d = irr_q;
        if (deliver) begin
            irr_d[lvl_q] = 1'b0;
        end
        irr_d = irr_d | rise;       // a new edge wins over a same-cycle clear

        isr_d = isr_q;
        if (wr_cmd && port_o[OCW_EOI_BIT]) begin
            isr_d = clear_lowest(isr_q);
        end
        if (deliver) begin
            isr_d[lvl_q] = 1'b1;
        end

        imr_d   = wr_imr ? port_o : imr_q;
        vbase_d = (wr_cmd && port_o[OCW_VEC_BIT]) ? port_o[7:3] : vbase_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            line_q  <= 8'h00;
            pclk_q  <= 1'b0;
            irr_q   <= 8'h00;
            isr_q   <= 8'h00;
            imr_q   <= 8'hFF;
            vbase_q <= VEC_RESET;
            irq_q   <= {VEC_RESET, 3'b000};
            intr_q  <= 1'b0;
            lvl_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            line_q  <= irq_line;
            pclk_q  <= port_clk;
            irr_q   <= irr_d;
            isr_q   <= isr_d;
            imr_q   <= imr_d;
            vbase_q <= vbase_d;
            irq_q   <= irq_d;
            intr_q  <= intr_d;
            lvl_q   <= lvl_d;
        end
    end

    assign port_sel = sel_cmd | sel_imr;
    assign port_rd  = sel_cmd ? irr_q : (sel_imr ? imr_q : 8'h00);
    assign irq      = irq_q;
    assign intr     = intr_q;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam logic [15:0] BASE = 16'h0020;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  irq_line;
    logic [15:0] port;
    logic        port_clk;
    logic        port_w;
    logic [7:0]  port_o;
    logic [7:0]  port_rd;
    logic        port_sel;
    logic [7:0]  irq;
    logic        intr;
    logic        intl;

    int total = 0;
    int bad   = 0;

    irq_controller #(.PORT_BASE(16'h0020), .VEC_RESET(5'h01)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .irq_line (irq_line),
        .port     (port),
        .port_clk (port_clk),
        .port_w   (port_w),
        .port_o   (port_o),
        .port_rd  (port_rd),
        .port_sel (port_sel),
        .irq      (irq),
        .intr     (intr),
        .intl     (intl)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural reference model ----------------
    // phase: 0 = waiting for an eligible request, 1 = selecting, 2 = delivered
    logic [7:0] m_line, m_irr, m_isr, m_imr, m_vec;
    logic       m_pclk, m_intr;
    int         m_vb, m_phase, m_lvl;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        logic [7:0] rise, pend, n_irr, n_isr, n_imr, n_vec;
        logic       strobe, n_intr;
        int         n_vb, n_phase, n_lvl, cand, e;
        bit         blocked;
        if (!reset_n) begin
            m_line = 0; m_pclk = 0; m_irr = 0; m_isr = 0; m_imr = 8'hFF;
            m_vb = 1; m_vec = 8'h08; m_intr = 0; m_phase = 0; m_lvl = 0;
            return;
        end
        rise = irq_line & ~m_line;
        strobe = port_clk && !m_pclk;
        pend = m_irr & ~m_imr;
        n_irr = m_irr; n_isr = m_isr; n_imr = m_imr; n_vec = m_vec;
        n_intr = m_intr; n_vb = m_vb; n_phase = m_phase; n_lvl = m_lvl;
        if (strobe && port_w && port == BASE) begin
            if (port_o[5]) begin
                e = lowest(m_isr);
                if (e >= 0) n_isr[e] = 1'b0;
            end
            if (port_o[4]) n_vb = int'(port_o) / 8;
        end
        if (strobe && port_w && port == BASE + 16'd1) n_imr = port_o;
        if (m_phase == 0) begin
            cand = lowest(pend);
            blocked = 0;
            for (int j = 0; j < 8; j++) if (m_isr[j] && j <= cand) blocked = 1;
            if (cand >= 0 && !blocked && m_intr == intl) begin
                n_phase = 1; n_lvl = cand;
            end
        end else if (m_phase == 1) begin
            if (pend[m_lvl]) begin
                n_vec = 8'(m_vb * 8 + m_lvl);
                n_intr = !m_intr;
                n_irr[m_lvl] = 1'b0;
                n_isr[m_lvl] = 1'b1;
                n_phase = 2;
            end else begin
                n_phase = 0;
            end
        end else if (intl == m_intr) begin
            n_phase = 0;
        end
        n_irr = n_irr | rise;
        m_irr = n_irr; m_isr = n_isr; m_imr = n_imr; m_vec = n_vec;
        m_intr = n_intr; m_vb = n_vb; m_phase = n_phase; m_lvl = n_lvl;
        m_line = irq_line; m_pclk = port_clk;
    endtask

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 0; intl = 0; irq_line = 0; port = 0;
        port_clk = 0; port_w = 0; port_o = 0;
        tick(); tick();
        reset_n = 1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        port = a; port_w = 1; port_o = d; port_clk = 1;
        tick();
        port_clk = 0; port_w = 0;
        tick();
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        port = a; port_w = 0;
        #1;
        d = port_rd;
    endtask

    task automatic pulse(input logic [7:0] m);
        irq_line = m;
        tick();
        irq_line = 0;
    endtask

    task automatic wait_intr(input string name, input logic want);
        for (int i = 0; i < 20 && intr !== want; i++) tick();
        check(name, intr, want);
    endtask

    task automatic idle_cycles(input string name, input int n, input logic want);
        bit moved = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (intr !== want) moved = 1;
        end
        check(name, moved, 0);
    endtask

    typedef struct {
        logic [7:0] imr;
        logic [7:0] lines;
        logic       exp_toggle;
        logic [7:0] exp_irq;
        logic [7:0] exp_irr;
    } vec_t;

    vec_t tbl[6];
    logic [7:0] d;

    initial begin
        tbl[0] = '{8'hFE, 8'h01, 1'b1, 8'h08, 8'h00};
        tbl[1] = '{8'h00, 8'h0A, 1'b1, 8'h09, 8'h08};
        tbl[2] = '{8'h00, 8'h80, 1'b1, 8'h0F, 8'h00};
        tbl[3] = '{8'hFF, 8'h10, 1'b0, 8'h08, 8'h10};
        tbl[4] = '{8'h02, 8'h06, 1'b1, 8'h0A, 8'h02};
        tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h08, 8'h00};

        // reset state and address decode
        do_reset();
        check("rst_intr", intr, 0);
        check("rst_irq", irq, 8'h08);
        rd(BASE, d);          check("rst_irr", d, 8'h00);
        check("sel_cmd", port_sel, 1);
        rd(BASE + 16'd1, d);  check("rst_imr", d, 8'hFF);
        check("sel_imr", port_sel, 1);
        rd(16'h0022, d);      check("unsel_rd", d, 8'h00);
        check("unsel_sel", port_sel, 0);

        // table: single-edge delivery with exact 3-clock latency
        for (int k = 0; k < 6; k++) begin
            do_reset();
            wr(BASE + 16'd1, tbl[k].imr);
            irq_line = tbl[k].lines;
            tick();
            irq_line = 0;
            tick();
            check($sformatf("tbl%0d_early", k), intr, 0);
            tick();
            check($sformatf("tbl%0d_intr", k), intr, tbl[k].exp_toggle);
            check($sformatf("tbl%0d_irq", k), irq, tbl[k].exp_irq);
            rd(BASE, d);
            check($sformatf("tbl%0d_irr", k), d, tbl[k].exp_irr);
        end

        // hold without ack, then ack: no second toggle
        do_reset();
        wr(BASE + 16'd1, 8'hFE);
        pulse(8'h01);
        wait_intr("t2_deliver", 1);
        idle_cycles("t2_hold", 10, 1);
        check("t2_irq", irq, 8'h08);
        intl = 1;
        idle_cycles("t2_no_retoggle", 8, 1);

        // simultaneous edges on 3 and 1, EOI releases 3
        do_reset();
        wr(BASE + 16'd1, 8'h00);
        pulse(8'h0A);
        wait_intr("t3_first", 1);
        check("t3_vec1", irq, 8'h09);
        intl = 1;
        idle_cycles("t3_blocked", 6, 1);
        wr(BASE, 8'h20);
        wait_intr("t3_second", 0);
        check("t3_vec3", irq, 8'h0B);
        intl = 0;

        // nesting: 5 in service, 2 preempts, 6 waits for both EOIs
        do_reset();
        wr(BASE + 16'd1, 8'h00);
        pulse(8'h20);
        wait_intr("t4_l5", 1);
        check("t4_vec5", irq, 8'h0D);
        intl = 1;
        tick();
        pulse(8'h04);
        wait_intr("t4_l2", 0);
        check("t4_vec2", irq, 8'h0A);
        intl = 0;
        tick();
        pulse(8'h40);
        idle_cycles("t4_l6_held", 8, 0);
        rd(BASE, d); check("t4_irr", d, 8'h40);
        wr(BASE, 8'h20);
        idle_cycles("t4_l6_held2", 6, 0);
        wr(BASE, 8'h20);
        wait_intr("t4_l6", 1);
        check("t4_vec6", irq, 8'h0E);
        intl = 1;

        // vector base programming, masked line 7
        do_reset();
        wr(BASE + 16'd1, 8'h00);
        wr(BASE, 8'h70);
        pulse(8'h80);
        wait_intr("t5_l7", 1);
        check("t5_vec", irq, 8'h77);
        intl = 1;
        tick();
        wr(BASE + 16'd1, 8'h80);
        pulse(8'h80);
        idle_cycles("t5_masked", 8, 1);
        rd(BASE, d); check("t5_irr", d, 8'h80);

        // reset during WAIT
        do_reset();
        wr(BASE + 16'd1, 8'h00);
        pulse(8'h08);
        wait_intr("t6_deliver", 1);
        reset_n = 0; intl = 0; irq_line = 8'h08;
        tick();
        check("t6_intr", intr, 0);
        check("t6_irq", irq, 8'h08);
        irq_line = 0;
        tick();
        reset_n = 1;
        rd(BASE, d);          check("t6_irr", d, 8'h00);
        rd(BASE + 16'd1, d);  check("t6_imr", d, 8'hFF);
        idle_cycles("t6_quiet", 5, 0);
        wr(BASE + 16'd1, 8'h00);
        pulse(8'h08);
        wait_intr("t6_isr_clear", 1);
        check("t6_vec", irq, 8'h0B);

        // randomized run against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 0; intl = 0;
            end else begin
                reset_n = 1;
                if (intl != m_intr && $urandom_range(0, 2) == 0) intl = m_intr;
            end
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) irq_line[b] = ~irq_line[b];
            if ($urandom_range(0, 2) == 0) port_clk = ~port_clk;
            case ($urandom_range(0, 2))
                0: port = BASE;
                1: port = BASE + 16'd1;
                default: port = 16'(BASE + 16'd2 + 16'($urandom_range(0, 3)));
            endcase
            port_w = 1'($urandom_range(0, 1));
            port_o = 8'($urandom) & 8'($urandom);
            tick();
            check("rand", {intr, irq, port_sel, port_rd},
                  {m_intr, m_vec,
                   (port == BASE || port == BASE + 16'd1),
                   (port == BASE) ? m_irr : (port == BASE + 16'd1) ? m_imr : 8'h00});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
